// File: rtl/mac16_dot_pkg.sv
// Shared definitions for the mac16_dot dot-product engine and its multiplier.
package mac16_dot_pkg;

  localparam int unsigned MUL_OP_W   = 16;
  localparam int unsigned MUL_PROD_W = 32;

  typedef struct packed {
    logic [MUL_OP_W-1:0] a;
    logic [MUL_OP_W-1:0] b;
    logic                last;
  } s0_t;

endpackage

// File: rtl/mul16_16.sv
// 16x16 unsigned combinational multiplier feeding the mac16_dot product register.
module mul16_16
  import mac16_dot_pkg::*;
(
  input  logic [MUL_OP_W-1:0]   a,
  input  logic [MUL_OP_W-1:0]   b,
  output logic [MUL_PROD_W-1:0] p
);

  always_comb begin
    p = MUL_PROD_W'(a) * MUL_PROD_W'(b);
  end

endmodule

// File: rtl/mac16_dot.sv
// Streaming unsigned dot-product engine: operand register, multiplier, product
// register and accumulator, with a single global stall under output backpressure.
module mac16_dot
  import mac16_dot_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_a,
  input  logic [MUL_OP_W-1:0] in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum,
  output logic [LEN_W-1:0]    out_count,
  output logic                out_ovf
);

  logic                  stall;
  logic                  accept;
  logic                  v0, v1;
  s0_t                   s0;
  logic [MUL_PROD_W-1:0] prod;
  logic [MUL_PROD_W-1:0] prod1;
  logic                  last1;
  logic [ACC_W-1:0]      acc;
  logic [LEN_W-1:0]      cnt;
  logic                  ovf;
  logic [ACC_W:0]        nxt;
  logic [LEN_W-1:0]      cnt_nxt;
  logic                  ovf_nxt;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = rst_n & ~stall;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      s0 <= '0;
    end else if (!stall) begin
      v0 <= accept;
      if (accept) begin
        s0 <= '{a: in_a, b: in_b, last: in_last};
      end
    end
  end

  mul16_16 u_mul (
    .a (s0.a),
    .b (s0.b),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      prod1 <= '0;
      last1 <= 1'b0;
    end else if (!stall) begin
      v1    <= v0;
      prod1 <= prod;
      last1 <= s0.last;
    end
  end

  always_comb begin
    nxt     = {1'b0, acc} + (ACC_W + 1)'(prod1);
    ovf_nxt = ovf | nxt[ACC_W];
    cnt_nxt = (&cnt) ? cnt : cnt + LEN_W'(1);
  end

  // The closing beat bypasses acc so the accumulator is already clear for the
  // first beat of the next vector, which may follow on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      out_valid <= v1 & last1;
      if (v1) begin
        if (last1) begin
          out_sum   <= nxt[ACC_W-1:0];
          out_count <= cnt_nxt;
          out_ovf   <= ovf_nxt;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= nxt[ACC_W-1:0];
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac16_dot.sv
// Randomized bench for mac16_dot against an arithmetic reference of whole-vector sums.
module tb_mac16_dot;

  localparam int unsigned ACC_W = 33;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [LEN_W-1:0] out_count;
  logic             out_ovf;

  mac16_dot #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned sum;
    longint unsigned cnt;
    bit              ovf;
  } res_t;

  res_t            exp_q[$];
  longint unsigned tot;
  longint unsigned nbeats;
  int              n_checks = 0;
  int              n_errors = 0;
  int              ready_mode;
  int              hold_left;
  int              stall_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-vector view: the wrapped sum carries out at least once exactly when
  // the true total reaches 2^ACC_W, since every product is non-negative.
  function automatic void model_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    res_t r;
    longint unsigned lim;
    tot    += 64'(a) * 64'(b);
    nbeats += 1;
    if (last) begin
      lim   = (64'd1 << ACC_W);
      r.sum = tot % lim;
      r.cnt = (nbeats > 64'((1 << LEN_W) - 1)) ? 64'((1 << LEN_W) - 1) : nbeats;
      r.ovf = (tot >= lim);
      exp_q.push_back(r);
      tot    = 0;
      nbeats = 0;
    end
  endfunction

  task automatic tick(output bit acc);
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        out_ready = (hold_left == 0);
        if (hold_left > 0) hold_left--;
      end
    endcase
    #1;
    acc = in_valid && in_ready;
    check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (out_valid && !out_ready) stall_cycles++;
    if (acc) model_beat(in_a, in_b, in_last);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        check("out_sum", 64'(out_sum), exp_q[0].sum);
        check("out_count", 64'(out_count), exp_q[0].cnt);
        check("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last, input int gap);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick(acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    acc      = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) tick(acc);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid   = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) tick(acc);
  endtask

  initial begin
    bit acc;
    int len;
    logic [15:0] ra, rb;
    tot = 0; nbeats = 0; ready_mode = 0; hold_left = 0; stall_cycles = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat with latency: accepted at edge k, visible after edge k+2.
    send(16'd3, 16'd5, 1'b1, 0);
    check("lat_k0", 64'(out_valid), 64'd0);
    tick(acc);
    check("lat_k1", 64'(out_valid), 64'd0);
    tick(acc);
    check("lat_k2", 64'(out_valid), 64'd1);
    check("lat_sum", 64'(out_sum), 64'd15);
    drain();

    // Back-to-back vectors; the second confirms the accumulator cleared.
    for (int i = 1; i <= 4; i++) send(16'(i), 16'(i), (i == 4), 0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 0);
    drain();

    // Overflow on the 33-bit accumulator, then a clean vector.
    for (int i = 0; i < 3; i++) send(16'hFFFF, 16'hFFFF, (i == 2), 0);
    send(16'd1, 16'd1, 1'b1, 0);
    drain();

    // Bubbles between beats.
    for (int i = 1; i <= 4; i++) send(16'(i), 16'(i), (i == 4), $urandom_range(0, 3));
    drain();

    // Backpressure: hold out_ready low while further beats are offered.
    ready_mode = 2; hold_left = 14; stall_cycles = 0;
    send(16'd100, 16'd200, 1'b0, 0);
    send(16'd300, 16'd400, 1'b1, 0);
    for (int i = 0; i < 3; i++) send(16'(i + 7), 16'(i + 11), (i == 2), 0);
    send(16'd9, 16'd9, 1'b1, 0);
    check("stall_seen", 64'(stall_cycles > 0), 64'd1);
    drain();

    // Reset mid-vector discards in-flight beats.
    send(16'd7, 16'd9, 1'b0, 0);
    send(16'd10, 16'd11, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_sum", 64'(out_sum), 64'd0);
    check("mid_rst_out_count", 64'(out_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tot = 0; nbeats = 0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'd2, 16'd3, 1'b1, 0);
    drain();

    // Randomized vectors, bubbles and backpressure; long ones saturate the count.
    ready_mode = 1;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        send(ra, rb, (i == len - 1), $urandom_range(0, 2));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
